// File: rtl/branch_target_unit.sv
// Branch/jal/jalr target generator with a registered result stage, misaligned-target
// detection and a circular return address stack for return-target prediction.
module branch_target_unit #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8,
    parameter int C_EXT     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] imm_b,
    input  logic [XLEN-1:0] imm_j,
    input  logic [XLEN-1:0] imm_i,
    output logic            out_valid,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link_addr,
    output logic            misaligned,
    output logic            ras_pred_valid,
    output logic [XLEN-1:0] ras_pred_addr
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OP_NONE   = 2'd0;
    localparam logic [1:0] OP_BRANCH = 2'd1;
    localparam logic [1:0] OP_JAL    = 2'd2;
    localparam logic [1:0] OP_JALR   = 2'd3;

    logic            out_valid_reg;
    logic [XLEN-1:0] target_reg, target_next;
    logic [XLEN-1:0] link_reg, link_next;
    logic            mis_reg, mis_next;
    logic            pred_valid_reg, pred_valid_next;
    logic [XLEN-1:0] pred_addr_reg, pred_addr_next;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   top_reg, top_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   wr_ptr;
    logic            wr_en;
    logic [RAS_DEPTH-1:0] wr_sel;

    logic accept, call_eff, ret_eff, do_push, do_pop, do_popush;
    logic [XLEN-1:0] jalr_sum;

    assign accept    = in_valid & ~flush;
    assign call_eff  = is_call & ((op == OP_JAL) | (op == OP_JALR));
    assign ret_eff   = is_ret & (op == OP_JALR);
    assign do_push   = accept & call_eff & ~ret_eff;
    assign do_pop    = accept & ret_eff & ~call_eff;
    assign do_popush = accept & ret_eff & call_eff;

    assign link_next = pc + XLEN'(4);
    assign jalr_sum  = rs1_data + imm_i;

    always_comb begin
        target_next = link_next;
        case (op)
            OP_BRANCH: target_next = pc + imm_b;
            OP_JAL:    target_next = pc + imm_j;
            OP_JALR:   target_next = jalr_sum & ~XLEN'(1);
            default:   target_next = link_next;
        endcase
    end

    // Flag is raised on the taken target regardless of branch outcome.
    always_comb begin
        mis_next = 1'b0;
        if (C_EXT == 0) begin
            mis_next = (op != OP_NONE) & target_next[1];
        end
    end

    always_comb begin
        top_next        = top_reg;
        count_next      = count_reg;
        wr_en           = 1'b0;
        wr_ptr          = top_reg;
        pred_valid_next = 1'b0;
        pred_addr_next  = '0;
        if (do_push) begin
            top_next = top_reg + PW'(1);
            wr_en    = 1'b1;
            wr_ptr   = top_reg + PW'(1);
            if (count_reg != CW'(RAS_DEPTH)) begin
                count_next = count_reg + CW'(1);
            end
        end else if (do_pop) begin
            if (count_reg != '0) begin
                pred_valid_next = 1'b1;
                pred_addr_next  = ras_mem[top_reg];
                top_next        = top_reg - PW'(1);
                count_next      = count_reg - CW'(1);
            end
        end else if (do_popush) begin
            // Replace the top in place; an empty stack gains its first entry.
            wr_en = 1'b1;
            if (count_reg != '0) begin
                pred_valid_next = 1'b1;
                pred_addr_next  = ras_mem[top_reg];
            end else begin
                count_next = CW'(1);
            end
        end
    end

    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en & (wr_ptr == PW'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
            top_reg   <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                if (wr_sel[i]) begin
                    ras_mem[i] <= link_next;
                end
            end
            top_reg   <= top_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            target_reg     <= '0;
            link_reg       <= '0;
            mis_reg        <= 1'b0;
            pred_valid_reg <= 1'b0;
            pred_addr_reg  <= '0;
        end else begin
            out_valid_reg <= accept;
            if (accept) begin
                target_reg     <= target_next;
                link_reg       <= link_next;
                mis_reg        <= mis_next;
                pred_valid_reg <= pred_valid_next;
                pred_addr_reg  <= pred_addr_next;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign target         = target_reg;
    assign link_addr      = link_reg;
    assign misaligned     = mis_reg;
    assign ras_pred_valid = pred_valid_reg;
    assign ras_pred_addr  = pred_addr_reg;

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Next-generation branch/jump target generator for the RV32I core.
- Computes branch, jal and jalr targets and the link address (pc+4) from decode-stage operands, and registers them for the execute/PC-select stage.
- Adds misaligned-target detection and a return address stack (RAS) that predicts return targets.
- Parametrised in data width, RAS depth and instruction alignment.

Parameters:
- XLEN, 32, width of pc, operands, immediates and targets.
- RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.
- C_EXT, 0, 0 = 4-byte instruction alignment; 1 = 2-byte alignment (compressed instructions present).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- flush  input  1  kill the in-flight and current operation.
- op  input  2  0=NONE, 1=BRANCH, 2=JAL, 3=JALR.
- is_call  input  1  rd is x1/x5 (link write); meaningful for JAL/JALR.
- is_ret  input  1  JALR with rs1 in {x1,x5} and rs1!=rd.
- pc  input  XLEN  instruction address.
- rs1_data  input  XLEN  rs1 value.
- imm_b, imm_j, imm_i  input  XLEN  sign-extended immediates.
- out_valid  output  1  registered result valid.
- target  output  XLEN  selected target address.
- link_addr  output  XLEN  pc+4.
- misaligned  output  1  target violates alignment (raise instruction-address-misaligned).
- ras_pred_valid  output  1  RAS supplied a return prediction.
- ras_pred_addr  output  XLEN  predicted return address.

Behaviour:
- Reset:
  - All outputs are 0.
  - RAS count, top pointer and all entries are 0.
  - Reset wins over every other input in the same cycle.
- Accept: in_valid=1 and flush=0. Latency is exactly 1 cycle, and a new operation can be accepted every cycle.
- out_valid (next cycle) = in_valid & ~flush. A flush in cycle N clears out_valid in cycle N+1, even if the operation was accepted in cycle N-1.
- Target arithmetic, modulo 2^XLEN (wrap-around, no overflow flag):
  - BRANCH: pc+imm_b.
  - JAL: pc+imm_j.
  - JALR: (rs1_data+imm_i) with bit 0 cleared.
  - NONE: target = pc+4.
- link_addr = pc+4, computed modulo 2^XLEN for all ops.
- misaligned:
  - C_EXT=0: target[1], evaluated for BRANCH, JAL and JALR only.
  - C_EXT=1: always 0.
  - Reported for the taken target whether or not the branch resolves taken; the consumer qualifies it.
- On a cycle without an accepted input, the registered target, link_addr, misaligned and ras_pred_* hold their values. Only out_valid drops.
- RAS is a circular buffer. It updates only on an accepted op (JAL or JALR):
  - Push (is_call & ~is_ret): top advances and the new top gets link_addr; count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten silently.
  - Pop (is_ret & ~is_call, op=JALR): if count>0, ras_pred_valid=1, ras_pred_addr=old top, then top retreats and count decrements. If count=0, ras_pred_valid=0, ras_pred_addr=0, and the RAS is unchanged.
  - Pop-then-push (is_ret & is_call, op=JALR): the prediction is the old top (valid if count>0). The top entry is replaced with link_addr in place; count is unchanged, except that an empty RAS becomes count=1.
  - is_ret with op!=JALR and is_call with op NONE/BRANCH are ignored.
- For every accepted op with no pop, ras_pred_valid=0.
- flush in the same cycle as in_valid suppresses that cycle's RAS update. Earlier updates are not rolled back.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle: all outputs 0. Then BRANCH pc=0x100, imm_b=0xFFFFFFF0 -> next cycle out_valid=1, target=0xF0, link_addr=0x104, misaligned=0.
- JALR rs1_data=0x2003, imm_i=0: with C_EXT=0 -> target=0x2002, misaligned=1. Same stimulus with C_EXT=1 -> misaligned=0.
- Wrap-around: JAL pc=0xFFFFFFFC, imm_j=8 -> target=0x4, link_addr=0x0.
- Call/return: JAL is_call pc=0x40, then JAL is_call pc=0x80, then two JALR is_ret -> ras_pred_addr 0x84 then 0x44, both with ras_pred_valid=1. A third return -> ras_pred_valid=0.
- Overflow: RAS_DEPTH+1 calls at pc=0x0,0x10,... then RAS_DEPTH returns -> predictions run newest down to pc=0x14 (second call). The oldest entry (0x4) is lost, and the next return gives ras_pred_valid=0.
- Flush and reset:
  - in_valid with flush=1 on a call -> out_valid=0 next cycle and no RAS push; a later return shows the prior top.
  - rst asserted mid-stream with count=3 -> outputs 0 and the RAS is empty.
